// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush sequencer: 3-entry write scoreboard (EX/MEM/WB), RAW stall and post-redirect squash.
// Latency: pc_hold/bubble combinational from state + ID inputs; silence registered (cycle after redirect).
// Backpressure: pc_hold freezes PC and IF/ID; optional forwarding selects under PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AWIDTH  = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_AWIDTH-1:0] id_rs_addr,
    input  logic                  id_rs_used,
    input  logic [REG_AWIDTH-1:0] id_rt_addr,
    input  logic                  id_rt_used,
    input  logic [REG_AWIDTH-1:0] id_wb_addr,
    input  logic                  id_wr,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    output logic                  pc_hold,
    output logic                  bubble,
    output logic                  silence,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`ifdef PIPE_HAZARD_FWD_EN
    ,
    output logic [1:0]            fwd_rs_sel,
    output logic [1:0]            fwd_rt_sel
`endif
);

    typedef struct packed {
        logic                  vld;
        logic [REG_AWIDTH-1:0] addr;
        logic                  is_load;
    } sb_t;

    typedef enum logic {RUN, FLUSH} state_e;

    // index 0 = EX, 1 = MEM, 2 = WB
    sb_t                 sb_q [3];
    sb_t                 sb_d [3];
    state_e              state_q, state_d;
    logic [1:0]          flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic [2:0] rs_hit, rt_hit;
    logic       hazard;

    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int i = 0; i < 3; i++) begin
            rs_hit[i] = sb_q[i].vld && (sb_q[i].addr == id_rs_addr) && (id_rs_addr != '0);
            rt_hit[i] = sb_q[i].vld && (sb_q[i].addr == id_rt_addr) && (id_rt_addr != '0);
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = id_valid && sb_q[0].is_load &&
                    ((id_rs_used && rs_hit[0]) || (id_rt_used && rt_hit[0]));

    function automatic logic [1:0] fwd_sel(input logic [2:0] hit);
        if (hit[0])      return 2'b01;
        else if (hit[1]) return 2'b10;
        else if (hit[2]) return 2'b11;
        else             return 2'b00;
    endfunction

    assign fwd_rs_sel = fwd_sel(rs_hit);
    assign fwd_rt_sel = fwd_sel(rt_hit);
`else
    // WB is included: the register file has no write-through.
    assign hazard = id_valid && ((id_rs_used && (|rs_hit)) || (id_rt_used && (|rt_hit)));
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // FSM: next state; a redirect seen during FLUSH is ignored
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 2'(FLUSH_DEPTH);
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q == 2'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs; redirect beats stall so the PC takes the new target
    always_comb begin
        pc_hold = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    pc_hold = 1'b1;
                    bubble  = 1'b1;
                end
            end
            FLUSH:   bubble = 1'b1;
            default: ;
        endcase
    end

    assign silence   = (state_q == FLUSH);
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        sb_d[0].vld     = id_valid && id_wr && !bubble;
        sb_d[0].addr    = id_wb_addr;
        sb_d[0].is_load = id_is_load;
        sb_d[1]         = sb_q[0];
        sb_d[2]         = sb_q[1];
        stall_cnt_d     = stall_cnt_q;
        if (pc_hold && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) sb_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) sb_q[i] <= sb_d[i];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{sb_q[0].is_load, sb_q[1].is_load, sb_q[2].is_load};

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and flush sequencer for the 16-bit 5-stage MIPS pipeline.
- Keeps a 3-entry scoreboard of in-flight register writes (EX, MEM, WB).
- Stalls fetch/decode on read-after-write hazards and squashes wrong-path instructions after a taken branch or jump.
- Drives the PC hold, the ID→EX bubble and the ROM silence mux. It sits beside `control` and needs no change to the datapath muxes.

Parameters:
- REG_AWIDTH, 4: register-file address width.
- FLUSH_DEPTH, 2: number of fetched instructions squashed after a redirect (1..3).
- CNT_WIDTH, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  a real (non-silenced) instruction is in ID.
- id_rs_addr  in  REG_AWIDTH  rs source address of the ID instruction.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_addr  in  REG_AWIDTH  rt source address.
- id_rt_used  in  1  ID instruction reads rt.
- id_wb_addr  in  REG_AWIDTH  destination address, after the WB mux select.
- id_wr  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a RAM load.
- ex_redirect  in  1  instruction in EX is a taken branch or a jump; 1-cycle pulse.
- pc_hold  out  1  freeze PC and the IF/ID register this cycle.
- bubble  out  1  zero the ID→EX control word this cycle.
- silence  out  1  force the ROM data into ID to NOP (drives SILENCE_MUX).
- stall_cnt  out  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Reset: asynchronous, clears all scoreboard entries to invalid and the flush counter to 0, and enters RUN.
  - pc_hold=0, bubble=0, silence=0, stall_cnt=0.
  - Reset asserted mid-flush or mid-stall aborts immediately.
- Scoreboard: entries SB_EX, SB_MEM, SB_WB; each holds {valid, addr, is_load}. Every clock they shift EX→MEM→WB and SB_WB is discarded.
  - SB_EX loads {id_valid & id_wr & ~bubble, id_wb_addr, id_is_load}.
  - When bubble=1, SB_EX loads invalid.
- match(a) = (a != 0) & (an entry with valid & addr==a exists). Address 0 never creates a hazard.
- hazard = id_valid & ((id_rs_used & match(id_rs_addr)) | (id_rt_used & match(id_rt_addr))).
  - WB is included because the register file has no write-through.
- FSM states: RUN, FLUSH.
  - RUN: if ex_redirect, go to FLUSH and load flush_cnt=FLUSH_DEPTH. Otherwise, if hazard, assert pc_hold=1 and bubble=1 combinationally in the same cycle and stay in RUN.
  - FLUSH: silence=1 and bubble=1 each cycle; flush_cnt decrements; return to RUN when flush_cnt reaches 1 (FLUSH_DEPTH cycles total).
  - In FLUSH, hazard is ignored and pc_hold=0.
- Redirect cycle (ex_redirect=1 in RUN):
  - bubble=1, because the ID instruction is wrong-path.
  - pc_hold=0, even if hazard=1, so the PC takes the new target.
  - Redirect takes priority over stall.
- ex_redirect during FLUSH cannot occur legally, since EX holds only bubbles. It is ignored and must not restart the count.
- Output timing:
  - pc_hold and bubble are combinational from registered state plus ID inputs.
  - silence is a registered state decode and goes high the cycle after the redirect.
- stall_cnt: increments by 1 on each clock where pc_hold=1 and saturates at all-ones.
- Latency: a RAW dependent instruction needs at most 3 stall cycles (producer in EX); it stalls 1 cycle when the producer is in WB.

Optional Feature:
- Macro: PIPE_HAZARD_FWD_EN.
- When defined:
  - Add outputs fwd_rs_sel[1:0] and fwd_rt_sel[1:0]: 00 = regfile, 01 = EX result, 10 = MEM result, 11 = WB result. The youngest matching valid entry wins.
  - hazard is reduced to the load-use case only: SB_EX.valid & SB_EX.is_load & matching source, giving 1 stall cycle.
  - In that stall cycle the forwarding selects still reflect the current SB state.
- When undefined: the ports are absent and the full-scoreboard stalling above applies.

Test Plan:
- Write r3 in ID (id_wr=1, id_wb_addr=3), next cycle ID reads rs=3 → pc_hold=bubble=1 for 3 consecutive cycles, then 0; stall_cnt=3.
- Write r0, then read rs=0 → no stall; pc_hold=0; stall_cnt unchanged.
- ex_redirect pulse while hazard=1 in ID → same cycle pc_hold=0, bubble=1; silence=1 for the next 2 cycles (FLUSH_DEPTH=2); no stall counted.
- Assert rst during the 2nd FLUSH cycle → silence, bubble and pc_hold go 0 asynchronously; the scoreboard is empty, so a following read of any register does not stall.
- Force stall_cnt to near saturation (CNT_WIDTH=4, 17 stall cycles) → stall_cnt holds at 15.
- With PIPE_HAZARD_FWD_EN: ALU write r5, then read r5 → 0 stalls, fwd_rs_sel=01. Load r5, then read r5 → 1 stall, then fwd_rs_sel=10.
